// File: rtl/conv2d_seq.sv
// Sequential 3x3 convolution: one MAC per cycle over a snapshot of image, kernel and bias.
// Optional output saturation when CONV_SATURATE_EN is defined (default: two's-complement truncation).
module conv2d_seq #(
  parameter int in_width  = 5,
  parameter int out_width = 3,
  parameter int data_w    = 32,
  parameter int acc_w     = 72
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [in_width*in_width*data_w-1:0]  in_map,
  input  logic [9*data_w-1:0]                  kernel,
  input  logic [data_w-1:0]                    bias,
  output logic                                 busy,
  output logic                                 done,
  output logic [out_width*out_width*data_w-1:0] out_map
);

  localparam int NPIX_IN  = in_width * in_width;
  localparam int NPIX_OUT = out_width * out_width;
  localparam int IDX_W    = $clog2(NPIX_IN);
  localparam int OIDX_W   = (NPIX_OUT > 1) ? $clog2(NPIX_OUT) : 1;
  localparam int RC_W     = (out_width > 1) ? $clog2(out_width) : 1;
  localparam int PROD_W   = 2 * data_w;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_FIN} state_t;

  state_t                     state;
  logic signed [data_w-1:0]   img [NPIX_IN];
  logic signed [data_w-1:0]   w [9];
  logic signed [data_w-1:0]   bias_q;
  logic signed [data_w-1:0]   pix [NPIX_OUT];
  logic signed [acc_w-1:0]    acc;
  logic [RC_W-1:0]            r, c;
  logic [3:0]                 k;

  logic [1:0]                 ki, kj;
  logic [IDX_W-1:0]           tap_idx;
  logic [OIDX_W-1:0]          out_idx;
  logic signed [PROD_W-1:0]   prod;
  logic signed [acc_w-1:0]    prod_ext;
  logic signed [acc_w-1:0]    bias_in_ext;
  logic signed [acc_w-1:0]    bias_q_ext;
  logic signed [data_w-1:0]   narrowed;

  // Kernel tap k maps to row offset k/3 and column offset k%3.
  always_comb begin
    ki = 2'd0;
    kj = 2'd0;
    case (k)
      4'd0: begin ki = 2'd0; kj = 2'd0; end
      4'd1: begin ki = 2'd0; kj = 2'd1; end
      4'd2: begin ki = 2'd0; kj = 2'd2; end
      4'd3: begin ki = 2'd1; kj = 2'd0; end
      4'd4: begin ki = 2'd1; kj = 2'd1; end
      4'd5: begin ki = 2'd1; kj = 2'd2; end
      4'd6: begin ki = 2'd2; kj = 2'd0; end
      4'd7: begin ki = 2'd2; kj = 2'd1; end
      4'd8: begin ki = 2'd2; kj = 2'd2; end
      default: begin ki = 2'd0; kj = 2'd0; end
    endcase
  end

  always_comb begin
    tap_idx     = IDX_W'((32'(r) + 32'(ki)) * in_width + 32'(c) + 32'(kj));
    out_idx     = OIDX_W'(32'(r) * out_width + 32'(c));
    prod        = img[tap_idx] * w[k];
    prod_ext    = {{(acc_w-PROD_W){prod[PROD_W-1]}}, prod};
    bias_in_ext = {{(acc_w-data_w){bias[data_w-1]}}, bias};
    bias_q_ext  = {{(acc_w-data_w){bias_q[data_w-1]}}, bias_q};
  end

`ifdef CONV_SATURATE_EN
  localparam logic signed [acc_w-1:0] SAT_MAX = {{(acc_w-data_w+1){1'b0}}, {(data_w-1){1'b1}}};
  localparam logic signed [acc_w-1:0] SAT_MIN = {{(acc_w-data_w+1){1'b1}}, {(data_w-1){1'b0}}};
  always_comb begin
    if (acc > SAT_MAX)      narrowed = SAT_MAX[data_w-1:0];
    else if (acc < SAT_MIN) narrowed = SAT_MIN[data_w-1:0];
    else                    narrowed = acc[data_w-1:0];
  end
`else
  always_comb narrowed = acc[data_w-1:0];
`endif

  // Operand snapshot: later input changes cannot disturb a run in progress.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start && !rst) begin
      for (int i = 0; i < NPIX_IN; i++) img[i] <= in_map[i*data_w +: data_w];
      for (int i = 0; i < 9; i++)       w[i]   <= kernel[i*data_w +: data_w];
      bias_q <= bias;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      acc   <= '0;
      r     <= '0;
      c     <= '0;
      k     <= '0;
      for (int p = 0; p < NPIX_OUT; p++) pix[p] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= bias_in_ext;
            r     <= '0;
            c     <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          if (k == 4'd8) state <= S_WRITE;
          else           k     <= k + 4'd1;
        end
        S_WRITE: begin
          pix[out_idx] <= narrowed;
          acc          <= bias_q_ext;
          k            <= '0;
          if (c == RC_W'(out_width-1)) begin
            c <= '0;
            if (r == RC_W'(out_width-1)) begin
              r     <= '0;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              r     <= r + 1'b1;
              state <= S_MAC;
            end
          end else begin
            c     <= c + 1'b1;
            state <= S_MAC;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NPIX_OUT; p++) begin : g_out
    assign out_map[p*data_w +: data_w] = pix[p];
  end

endmodule

// File: tb/tb_conv2d_seq.sv
// Directed vector bench for conv2d_seq: table of runs plus start-hold and mid-run reset sequences.
module tb_conv2d_seq;

  localparam int IW = 5;
  localparam int OW = 3;
  localparam int DW = 32;
  localparam int IMG_B = IW*IW*DW;
  localparam int KER_B = 9*DW;
  localparam int OUT_B = OW*OW*DW;
  localparam int NVEC  = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [IMG_B-1:0] in_map = '0;
  logic [KER_B-1:0] kernel = '0;
  logic [DW-1:0]    bias = '0;
  logic             busy, done;
  logic [OUT_B-1:0] out_map;

  int checks = 0;
  int errors = 0;

  conv2d_seq #(.in_width(IW), .out_width(OW), .data_w(DW), .acc_w(72)) dut (
    .clk(clk), .rst(rst), .start(start), .in_map(in_map), .kernel(kernel),
    .bias(bias), .busy(busy), .done(done), .out_map(out_map)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IMG_B-1:0] img;
    logic [KER_B-1:0] kern;
    logic [DW-1:0]    bias;
    logic [OUT_B-1:0] exp;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int vi);
    int n;
    int busy_cnt;
    in_map = vecs[vi].img;
    kernel = vecs[vi].kern;
    bias   = vecs[vi].bias;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_cnt++;
    end
    chk($sformatf("v%0d_done_latency", vi), n, 90);
    chk($sformatf("v%0d_busy_cycles", vi), busy_cnt, 91);
    for (int p = 0; p < OW*OW; p++)
      chk($sformatf("v%0d_pix%0d", vi, p), out_map[p*DW +: DW], vecs[vi].exp[p*DW +: DW]);
    @(posedge clk); #1;
    chk($sformatf("v%0d_busy_after", vi), {31'd0, busy}, 0);
    chk($sformatf("v%0d_done_after", vi), {31'd0, done}, 0);
  endtask

  initial begin
    int id_exp [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    int tap_exp [9] = '{14, 17, 20, 29, 32, 35, 44, 47, 50};
    int n, dcnt, d1, d2;
    logic [31:0] ovf;

`ifdef CONV_SATURATE_EN
    ovf = 32'h7FFFFFFF;
`else
    ovf = 32'h00000000;
`endif

    for (int v = 0; v < NVEC; v++) begin
      vecs[v].img = '0; vecs[v].kern = '0; vecs[v].bias = '0; vecs[v].exp = '0;
    end
    // 0: identity kernel over ramp image
    for (int i = 0; i < 25; i++) vecs[0].img[i*DW +: DW] = i;
    vecs[0].kern[4*DW +: DW] = 1;
    for (int p = 0; p < 9; p++) vecs[0].exp[p*DW +: DW] = id_exp[p];
    // 1: all-ones kernel and image, bias -100
    for (int i = 0; i < 25; i++) vecs[1].img[i*DW +: DW] = 1;
    for (int i = 0; i < 9; i++) vecs[1].kern[i*DW +: DW] = 1;
    vecs[1].bias = -100;
    for (int p = 0; p < 9; p++) vecs[1].exp[p*DW +: DW] = 32'hFFFFFFA5;
    // 2: overflow
    for (int i = 0; i < 25; i++) vecs[2].img[i*DW +: DW] = 32'h40000000;
    for (int i = 0; i < 9; i++) vecs[2].kern[i*DW +: DW] = 32'h40000000;
    for (int p = 0; p < 9; p++) vecs[2].exp[p*DW +: DW] = ovf;
    // 3: negative weight
    for (int i = 0; i < 25; i++) vecs[3].img[i*DW +: DW] = 7;
    vecs[3].kern[0 +: DW] = -3;
    vecs[3].bias = 5;
    for (int p = 0; p < 9; p++) vecs[3].exp[p*DW +: DW] = -16;
    // 4: opposite corner taps: img(r,c) - img(r+2,c+2) + 2
    for (int i = 0; i < 25; i++) vecs[4].img[i*DW +: DW] = i;
    vecs[4].kern[0 +: DW] = 1;
    vecs[4].kern[8*DW +: DW] = -1;
    vecs[4].bias = 2;
    for (int p = 0; p < 9; p++) vecs[4].exp[p*DW +: DW] = -10;
    // 5: asymmetric taps w(0,2)=2, w(2,0)=1
    for (int i = 0; i < 25; i++) vecs[5].img[i*DW +: DW] = i;
    vecs[5].kern[2*DW +: DW] = 2;
    vecs[5].kern[6*DW +: DW] = 1;
    for (int p = 0; p < 9; p++) vecs[5].exp[p*DW +: DW] = tap_exp[p];

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    for (int p = 0; p < 9; p++) chk($sformatf("rst_pix%0d", p), out_map[p*DW +: DW], 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < NVEC; v++) run_vec(v);
    // back-to-back repeat of the negative-weight run
    run_vec(3);
    run_vec(3);

    // start held high, image changed mid-run
    in_map = vecs[0].img; kernel = vecs[0].kern; bias = '0;
    start = 1'b1;
    @(posedge clk); #1;
    dcnt = 0; d1 = -1; d2 = -1;
    for (n = 1; n <= 186; n++) begin
      @(posedge clk); #1;
      if (n == 5) for (int i = 0; i < 25; i++) in_map[i*DW +: DW] = 1;
      if (done) begin
        dcnt++;
        if (d1 < 0) d1 = n; else if (d2 < 0) d2 = n;
      end
      if (n == 91) begin
        chk("hold_busy_gap", {31'd0, busy}, 0);
        for (int p = 0; p < 9; p++)
          chk($sformatf("hold_pix%0d", p), out_map[p*DW +: DW], vecs[0].exp[p*DW +: DW]);
      end
      if (n == 92) chk("hold_restart_busy", {31'd0, busy}, 1);
      if (n == 95) start = 1'b0;
    end
    chk("hold_first_done", d1, 90);
    chk("hold_second_done", d2, 182);
    chk("hold_done_count", dcnt, 2);
    for (int p = 0; p < 9; p++) chk($sformatf("hold2_pix%0d", p), out_map[p*DW +: DW], 1);

    // reset in the middle of a run
    in_map = vecs[5].img; kernel = vecs[5].kern; bias = vecs[5].bias;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_done", {31'd0, done}, 0);
    for (int p = 0; p < 9; p++) chk($sformatf("mrst_pix%0d", p), out_map[p*DW +: DW], 0);
    dcnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("mrst_no_done", dcnt, 0);
    run_vec(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
